// File: rtl/main_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : main_cache_pkg
// Brief    : Geometry, FSM states and tree-PLRU helpers for the main cache.
// Revision : 1.0 - initial release
// ============================================================================
package main_cache_pkg;

    localparam int S_WAY     = 2;
    localparam int S_WAY_NUM = 4;
    localparam int S_PLRU    = 3;
    localparam int S_INDEX   = 4;
    localparam int S_MASK    = 32;
    localparam int S_SETS    = 1 << S_INDEX;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SWAP  = 2'd2,
        FILL  = 2'd3
    } state_t;

    // Point the tree away from the touched way; the other pair's bit is kept.
    function automatic logic [S_PLRU-1:0] plru_touch(input logic [S_PLRU-1:0] plru,
                                                     input logic [S_WAY-1:0]  way);
        logic [S_PLRU-1:0] w_next;
        w_next    = plru;
        w_next[0] = ~way[1];
        if (way[1]) w_next[2] = ~way[0];
        else        w_next[1] = ~way[0];
        return w_next;
    endfunction

    function automatic logic [S_WAY-1:0] plru_victim(input logic [S_PLRU-1:0] plru);
        return plru[0] ? {1'b1, plru[2]} : {1'b0, plru[1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/main_cache_victim_sel.sv
`default_nettype none
// ============================================================================
// Module   : main_cache_victim_sel
// Brief    : Picks the lowest invalid way, else the tree-PLRU victim.
// Revision : 1.0 - initial release
// ============================================================================
module main_cache_victim_sel
    import main_cache_pkg::*;
(
    input  logic [S_WAY_NUM-1:0] i_valid_row,
    input  logic [S_PLRU-1:0]    i_plru,
    output logic [S_WAY-1:0]     o_victim
);

    // Scan downwards so the lowest invalid way wins.
    always_comb begin
        o_victim = plru_victim(i_plru);
        for (int i = S_WAY_NUM - 1; i >= 0; i--) begin
            if (!i_valid_row[i]) o_victim = S_WAY'(i);
        end
    end

endmodule
`default_nettype wire

// File: rtl/main_cache_control.sv
`default_nettype none
// ============================================================================
// Module   : main_cache_control
// Brief    : Control FSM for the 4-way main cache: hits, PLRU, victim swap, fill.
// Revision : 1.0 - initial release
// ============================================================================
module main_cache_control
    import main_cache_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [S_MASK-1:0]    mem_byte_enable256,
    input  logic [S_INDEX-1:0]   index,
    output logic                 mem_resp,
    input  logic                 hit,
    input  logic [S_WAY-1:0]     way_index,
    input  logic [S_PLRU-1:0]    plru_o,
    output logic [S_WAY_NUM-1:0] data_we,
    output logic [S_WAY_NUM-1:0] tag_we,
    output logic [S_WAY_NUM-1:0] dirty_we,
    output logic [S_WAY_NUM-1:0] valid_we,
    output logic                 plru_we,
    output logic [S_PLRU-1:0]    plru_i,
    output logic [S_MASK-1:0]    mask_val,
    output logic                 data_in_sel,
    output logic                 data_out_sel,
    output logic                 valid_i,
    output logic                 dirty_i,
    output logic [S_WAY-1:0]     evict_index,
    output logic                 fill_sel,
    output logic                 evict_valid,
    output logic                 victim_req,
    input  logic                 victim_resp,
    input  logic                 victim_hit,
    output logic                 pmem_read,
    input  logic                 pmem_resp
);

    state_t               r_state;
    state_t               w_state_next;
    logic [S_WAY_NUM-1:0] r_shadow [S_SETS];
    logic [S_WAY-1:0]     r_evict_index;
    logic [S_WAY-1:0]     w_victim;
    logic [S_WAY_NUM-1:0] w_row;
    logic [S_WAY_NUM-1:0] w_hit_onehot;
    logic [S_WAY_NUM-1:0] w_evict_onehot;
    logic                 w_hit_eff;
    logic                 w_install;

    // Datapath valid bits are not trusted after reset; the shadow gates hits.
    assign w_row          = r_shadow[index];
    assign w_hit_eff      = hit & w_row[way_index];
    assign w_hit_onehot   = S_WAY_NUM'(1) << way_index;
    assign w_evict_onehot = S_WAY_NUM'(1) << r_evict_index;
    assign evict_index    = r_evict_index;

    main_cache_victim_sel u_victim_sel (
        .i_valid_row (w_row),
        .i_plru      (plru_o),
        .o_victim    (w_victim)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_evict_index <= '0;
            for (int s = 0; s < S_SETS; s++) r_shadow[s] <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == CHECK && !w_hit_eff) r_evict_index <= w_victim;
            if (w_install) r_shadow[index][r_evict_index] <= 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_install    = 1'b0;
        mem_resp     = 1'b0;
        data_we      = '0;
        tag_we       = '0;
        dirty_we     = '0;
        valid_we     = '0;
        plru_we      = 1'b0;
        plru_i       = '0;
        mask_val     = '0;
        data_in_sel  = 1'b0;
        data_out_sel = 1'b0;
        valid_i      = 1'b0;
        dirty_i      = 1'b0;
        fill_sel     = 1'b0;
        evict_valid  = 1'b0;
        victim_req   = 1'b0;
        pmem_read    = 1'b0;

        case (r_state)
            IDLE: begin
                if (mem_read | mem_write) w_state_next = CHECK;
            end
            CHECK: begin
                if (w_hit_eff) begin
                    mem_resp     = 1'b1;
                    plru_we      = 1'b1;
                    plru_i       = plru_touch(plru_o, way_index);
                    // A simultaneous read and write is serviced as a write.
                    if (mem_write) begin
                        data_we  = w_hit_onehot;
                        dirty_we = w_hit_onehot;
                        mask_val = mem_byte_enable256;
                        dirty_i  = 1'b1;
                    end
                    w_state_next = IDLE;
                end else begin
                    w_state_next = SWAP;
                end
            end
            SWAP: begin
                victim_req   = 1'b1;
                data_out_sel = 1'b1;
                evict_valid  = w_row[r_evict_index];
                if (victim_resp) begin
                    if (victim_hit) begin
                        data_we      = w_evict_onehot;
                        tag_we       = w_evict_onehot;
                        valid_we     = w_evict_onehot;
                        dirty_we     = w_evict_onehot;
                        data_in_sel  = 1'b1;
                        mask_val     = '1;
                        valid_i      = 1'b1;
                        w_install    = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_state_next = FILL;
                    end
                end
            end
            FILL: begin
                pmem_read    = 1'b1;
                fill_sel     = 1'b1;
                data_out_sel = 1'b1;
                if (pmem_resp) begin
                    data_we      = w_evict_onehot;
                    tag_we       = w_evict_onehot;
                    valid_we     = w_evict_onehot;
                    dirty_we     = w_evict_onehot;
                    mask_val     = '1;
                    valid_i      = 1'b1;
                    w_install    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_main_cache_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_main_cache_control
// Brief    : Directed self-checking bench for main_cache_control.
// Revision : 1.0 - initial release
// ============================================================================
module tb_main_cache_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [31:0] mem_byte_enable256;
    logic [3:0]  index;
    logic        mem_resp;
    logic        hit;
    logic [1:0]  way_index;
    logic [2:0]  plru_o;
    logic [3:0]  data_we, tag_we, dirty_we, valid_we;
    logic        plru_we;
    logic [2:0]  plru_i;
    logic [31:0] mask_val;
    logic        data_in_sel, data_out_sel, valid_i, dirty_i;
    logic [1:0]  evict_index;
    logic        fill_sel, evict_valid, victim_req;
    logic        victim_resp, victim_hit, pmem_read, pmem_resp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    main_cache_control dut (
        .clk                (clk),
        .rst                (rst),
        .mem_read           (mem_read),
        .mem_write          (mem_write),
        .mem_byte_enable256 (mem_byte_enable256),
        .index              (index),
        .mem_resp           (mem_resp),
        .hit                (hit),
        .way_index          (way_index),
        .plru_o             (plru_o),
        .data_we            (data_we),
        .tag_we             (tag_we),
        .dirty_we           (dirty_we),
        .valid_we           (valid_we),
        .plru_we            (plru_we),
        .plru_i             (plru_i),
        .mask_val           (mask_val),
        .data_in_sel        (data_in_sel),
        .data_out_sel       (data_out_sel),
        .valid_i            (valid_i),
        .dirty_i            (dirty_i),
        .evict_index        (evict_index),
        .fill_sel           (fill_sel),
        .evict_valid        (evict_valid),
        .victim_req         (victim_req),
        .victim_resp        (victim_resp),
        .victim_hit         (victim_hit),
        .pmem_read          (pmem_read),
        .pmem_resp          (pmem_resp)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Read miss on idx that misses the victim cache and fills into 'way'.
    task automatic fill_way(input logic [3:0] idx, input logic [1:0] way);
        index = idx; mem_read = 1'b1; hit = 1'b0; plru_o = 3'b000;
        tick();
        tick();
        check("fill_evict_index", {30'd0, evict_index}, {30'd0, way});
        check("fill_victim_req", {31'd0, victim_req}, 32'd1);
        victim_resp = 1'b1; victim_hit = 1'b0;
        tick();
        victim_resp = 1'b0; pmem_resp = 1'b1;
        settle();
        check("fill_valid_we", {28'd0, valid_we}, 32'd1 << way);
        tick();
        pmem_resp = 1'b0;
        tick();
        hit = 1'b1; way_index = way;
        settle();
        check("fill_relookup_resp", {31'd0, mem_resp}, 32'd1);
        tick();
        mem_read = 1'b0; hit = 1'b0;
    endtask

    task automatic read_hit(input logic [3:0] idx, input logic [1:0] way,
                            input logic [2:0] plru_in, input logic [2:0] exp_plru);
        index = idx; mem_read = 1'b1; hit = 1'b1; way_index = way; plru_o = plru_in;
        tick();
        settle();
        check("rhit_resp", {31'd0, mem_resp}, 32'd1);
        check("rhit_plru_i", {29'd0, plru_i}, {29'd0, exp_plru});
        check("rhit_no_data_we", {28'd0, data_we}, 32'd0);
        tick();
        mem_read = 1'b0; hit = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable256 = '0;
        index = '0; hit = 1'b0; way_index = '0; plru_o = '0;
        victim_resp = 1'b0; victim_hit = 1'b0; pmem_resp = 1'b0;
        tick(); tick();
        rst = 1'b0;
        settle();
        check("rst_mem_resp", {31'd0, mem_resp}, 32'd0);
        check("rst_evict_index", {30'd0, evict_index}, 32'd0);
        check("rst_victim_req", {31'd0, victim_req}, 32'd0);
        check("rst_pmem_read", {31'd0, pmem_read}, 32'd0);

        // Cold read of set 3: miss, victim miss, fill way 0, re-lookup hit.
        index = 4'd3; mem_read = 1'b1;
        tick();
        settle();
        check("cold_check_noresp", {31'd0, mem_resp}, 32'd0);
        tick();
        check("cold_swap_req", {31'd0, victim_req}, 32'd1);
        check("cold_evict_valid", {31'd0, evict_valid}, 32'd0);
        check("cold_evict_index", {30'd0, evict_index}, 32'd0);
        check("cold_data_out_sel", {31'd0, data_out_sel}, 32'd1);
        tick();
        check("cold_swap_hold", {31'd0, victim_req}, 32'd1);
        victim_resp = 1'b1; victim_hit = 1'b0;
        tick();
        victim_resp = 1'b0;
        check("cold_fill_read", {31'd0, pmem_read}, 32'd1);
        check("cold_fill_sel", {31'd0, fill_sel}, 32'd1);
        check("cold_fill_no_we", {28'd0, valid_we}, 32'd0);
        tick();
        pmem_resp = 1'b1;
        settle();
        check("cold_valid_we", {28'd0, valid_we}, 32'h1);
        check("cold_data_we", {28'd0, data_we}, 32'h1);
        check("cold_dirty_i", {31'd0, dirty_i}, 32'd0);
        check("cold_valid_i", {31'd0, valid_i}, 32'd1);
        check("cold_mask", mask_val, 32'hFFFF_FFFF);
        check("cold_data_in_sel", {31'd0, data_in_sel}, 32'd0);
        tick();
        pmem_resp = 1'b0;
        check("cold_idle_no_read", {31'd0, pmem_read}, 32'd0);
        tick();
        hit = 1'b1; way_index = 2'd0; plru_o = 3'b000;
        settle();
        check("cold_relookup_resp", {31'd0, mem_resp}, 32'd1);
        check("cold_plru_we", {31'd0, plru_we}, 32'd1);
        check("cold_plru_i", {29'd0, plru_i}, 32'h3);
        tick();
        mem_read = 1'b0; hit = 1'b0;
        check("cold_resp_pulse", {31'd0, mem_resp}, 32'd0);

        // Populate all four ways of set 5 in order.
        for (int w = 0; w < 4; w++) fill_way(4'd5, 2'(w));

        // Write hit on way 2 with a low-byte mask.
        index = 4'd5; mem_write = 1'b1; mem_byte_enable256 = 32'h0000_000F;
        tick();
        hit = 1'b1; way_index = 2'd2; plru_o = 3'b000;
        settle();
        check("wr_resp", {31'd0, mem_resp}, 32'd1);
        check("wr_data_we", {28'd0, data_we}, 32'h4);
        check("wr_mask", mask_val, 32'h0000_000F);
        check("wr_dirty_we", {28'd0, dirty_we}, 32'h4);
        check("wr_dirty_i", {31'd0, dirty_i}, 32'd1);
        check("wr_plru_i", {29'd0, plru_i}, 32'h4);
        check("wr_fill_sel", {31'd0, fill_sel}, 32'd0);
        tick();
        mem_write = 1'b0; hit = 1'b0; mem_byte_enable256 = '0;

        // Accesses 2, 0, 1 leave the tree pointing at way 3.
        read_hit(4'd5, 2'd2, 3'b000, 3'b100);
        read_hit(4'd5, 2'd0, 3'b100, 3'b111);
        read_hit(4'd5, 2'd1, 3'b111, 3'b101);

        // Full set misses: tree victim is way 3, then the victim cache hits.
        index = 4'd5; mem_read = 1'b1; hit = 1'b0; plru_o = 3'b101;
        tick();
        settle();
        check("ev_check_noresp", {31'd0, mem_resp}, 32'd0);
        tick();
        check("ev_evict_index", {30'd0, evict_index}, 32'd3);
        check("ev_evict_valid", {31'd0, evict_valid}, 32'd1);
        tick(); tick();
        check("ev_req_held", {31'd0, victim_req}, 32'd1);
        victim_resp = 1'b1; victim_hit = 1'b1;
        settle();
        check("vh_data_we", {28'd0, data_we}, 32'h8);
        check("vh_tag_we", {28'd0, tag_we}, 32'h8);
        check("vh_valid_we", {28'd0, valid_we}, 32'h8);
        check("vh_dirty_we", {28'd0, dirty_we}, 32'h8);
        check("vh_data_in_sel", {31'd0, data_in_sel}, 32'd1);
        check("vh_mask", mask_val, 32'hFFFF_FFFF);
        check("vh_no_pmem", {31'd0, pmem_read}, 32'd0);
        tick();
        victim_resp = 1'b0; victim_hit = 1'b0;
        check("vh_idle_no_pmem", {31'd0, pmem_read}, 32'd0);
        tick();
        hit = 1'b1; way_index = 2'd3;
        settle();
        check("vh_relookup_resp", {31'd0, mem_resp}, 32'd1);
        check("vh_relookup_plru", {29'd0, plru_i}, 32'h0);
        tick();
        mem_read = 1'b0; hit = 1'b0;

        // Stray pmem_resp in IDLE has no effect.
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        settle();
        check("stray_no_resp", {31'd0, mem_resp}, 32'd0);
        check("stray_no_pmem", {31'd0, pmem_read}, 32'd0);
        check("stray_no_we", {28'd0, valid_we}, 32'd0);

        // Read and write together on a hit behave as a write.
        index = 4'd5; mem_read = 1'b1; mem_write = 1'b1; mem_byte_enable256 = 32'hFFFF_0000;
        tick();
        hit = 1'b1; way_index = 2'd1; plru_o = 3'b000;
        settle();
        check("rw_resp", {31'd0, mem_resp}, 32'd1);
        check("rw_data_we", {28'd0, data_we}, 32'h2);
        check("rw_dirty_we", {28'd0, dirty_we}, 32'h2);
        check("rw_mask", mask_val, 32'hFFFF_0000);
        check("rw_plru_i", {29'd0, plru_i}, 32'h1);
        tick();
        mem_read = 1'b0; mem_write = 1'b0; hit = 1'b0; mem_byte_enable256 = '0;

        // Reset in FILL abandons the request and clears the shadow.
        index = 4'd7; mem_read = 1'b1;
        tick(); tick();
        victim_resp = 1'b1; victim_hit = 1'b0;
        tick();
        victim_resp = 1'b0;
        check("rstf_pmem_read", {31'd0, pmem_read}, 32'd1);
        rst = 1'b1; mem_read = 1'b0;
        tick();
        rst = 1'b0;
        check("rstf_pmem_off", {31'd0, pmem_read}, 32'd0);
        check("rstf_fill_sel", {31'd0, fill_sel}, 32'd0);
        check("rstf_data_out_sel", {31'd0, data_out_sel}, 32'd0);
        check("rstf_evict_index", {30'd0, evict_index}, 32'd0);
        check("rstf_victim_req", {31'd0, victim_req}, 32'd0);
        check("rstf_mem_resp", {31'd0, mem_resp}, 32'd0);
        index = 4'd5; mem_read = 1'b1;
        tick();
        hit = 1'b1; way_index = 2'd1;
        settle();
        check("rstf_shadow_miss", {31'd0, mem_resp}, 32'd0);
        tick();
        check("rstf_swap_req", {31'd0, victim_req}, 32'd1);
        check("rstf_evict_valid", {31'd0, evict_valid}, 32'd0);
        rst = 1'b1; mem_read = 1'b0; hit = 1'b0;
        tick();
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
